// File: rtl/fft_frame_packer_if.sv
// Stream-in / FIFO-write bundle of fft_frame_packer. The packer takes the slave view;
// signal suffixes describe directions as seen from the packer.
interface fft_frame_packer_if #(
    parameter int DATA_WIDTH = 25
) ();
    logic                         sync_i;
    logic                         valid_i;
    logic                         ready_o;
    logic [3:0]                   chan_i;
    logic signed [DATA_WIDTH-1:0] re_i;
    logic signed [DATA_WIDTH-1:0] im_i;
    logic                         fifo_full_i;
    logic                         wr_en_o;
    logic [63:0]                  wr_data_o;

    modport slave (
        input  sync_i, valid_i, chan_i, re_i, im_i, fifo_full_i,
        output ready_o, wr_en_o, wr_data_o
    );

    modport master (
        output sync_i, valid_i, chan_i, re_i, im_i, fifo_full_i,
        input  ready_o, wr_en_o, wr_data_o
    );
endinterface

// File: rtl/fft_frame_packer.sv
// Packs complex FFT bins into tagged 64-bit re/im words for the ft245 write FIFO; frames are all-or-nothing.
// Optional FFT_FRAME_PACKER_PARITY_EN puts XOR of word bits [59:0] into bit 60.
module fft_frame_packer #(
    parameter int N_BINS     = 1024,
    parameter int DATA_WIDTH = 25,
    parameter int NUM_CHAN   = 1,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    fft_frame_packer_if.slave    bus,
    output logic                 frame_done_o,
    output logic [15:0]          drop_cnt_o
);

    localparam int BIN_W = $clog2(N_BINS);
    localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);

    if (OUT_WIDTH != 64) begin : g_bad_out_width
        $error("fft_frame_packer: OUT_WIDTH must be 64");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_data_width
        $error("fft_frame_packer: DATA_WIDTH must be 2..32");
    end
    if (NUM_CHAN < 1 || NUM_CHAN > 16) begin : g_bad_num_chan
        $error("fft_frame_packer: NUM_CHAN must be 1..16");
    end
    if (N_BINS < 4 || N_BINS > 32768 || (N_BINS & (N_BINS - 1)) != 0) begin : g_bad_n_bins
        $error("fft_frame_packer: N_BINS must be a power of 2 in 4..32768");
    end

    typedef enum logic [2:0] {S_IDLE, S_RE, S_IM, S_IM_WAIT, S_DROP} state_t;

    state_t                       state_q;
    logic [BIN_W-1:0]             bin_q;
    logic [3:0]                   chan_q;
    logic [7:0]                   fseq_q;
    logic signed [DATA_WIDTH-1:0] im_lat_q;
    logic [7:0]                   seq_q [2**CH_W];
    logic                         wr_en_q;
    logic [63:0]                  wr_data_q;
    logic                         frame_done_q;
    logic [15:0]                  drop_cnt_q;

    logic             accept, in_frame, last_bin, frame_end;
    logic             start, next_bin, truncate;
    logic [CH_W-1:0]  ch_idx, cur_idx;
    logic [7:0]       start_seq;
    logic [1:0]       drop_inc;
    logic [16:0]      drop_sum;

    function automatic logic [63:0] make_word(input logic [3:0] ch, input logic [7:0] sq,
                                              input logic imf, input logic [BIN_W-1:0] b,
                                              input logic signed [DATA_WIDTH-1:0] s);
        logic [63:0] w;
        w = {3'b100, 1'b0, ch, sq, imf, 15'(b), 32'(s)};
`ifdef FFT_FRAME_PACKER_PARITY_EN
        w[60] = ^w[59:0];
`endif
        return w;
    endfunction

    // A frame ending this cycle bumps its channel's sequence before a same-channel restart reads it.
    always_comb begin
        ch_idx    = bus.chan_i[CH_W-1:0];
        cur_idx   = chan_q[CH_W-1:0];
        accept    = bus.valid_i && (state_q != S_RE);
        in_frame  = (state_q == S_IM) || (state_q == S_IM_WAIT);
        last_bin  = (bin_q == LAST_BIN);
        frame_end = (state_q == S_IM) && last_bin;
        start     = accept && bus.sync_i;
        truncate  = accept && in_frame && !last_bin && (bus.sync_i || (bus.chan_i != chan_q));
        next_bin  = accept && in_frame && !last_bin && !bus.sync_i && (bus.chan_i == chan_q);
        start_seq = seq_q[ch_idx] + ((frame_end && (ch_idx == cur_idx)) ? 8'd1 : 8'd0);
        drop_inc  = 2'(truncate) + 2'((start || next_bin || (state_q == S_RE)) && bus.fifo_full_i);
        drop_sum  = 17'(drop_cnt_q) + 17'(drop_inc);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            chan_q       <= '0;
            fseq_q       <= '0;
            im_lat_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
            for (int i = 0; i < 2**CH_W; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (frame_end) begin
                seq_q[cur_idx] <= seq_q[cur_idx] + 8'd1;
                frame_done_q   <= 1'b1;
            end

            // Each word is committed one cycle ahead, so fifo_full_i is judged when loading it.
            if (state_q == S_RE) begin
                if (bus.fifo_full_i) begin
                    state_q <= S_DROP;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= make_word(chan_q, fseq_q, 1'b1, bin_q, im_lat_q);
                    state_q   <= S_IM;
                end
            end else if (start) begin
                chan_q   <= bus.chan_i;
                bin_q    <= '0;
                fseq_q   <= start_seq;
                im_lat_q <= bus.im_i;
                if (bus.fifo_full_i) begin
                    state_q <= S_DROP;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= make_word(bus.chan_i, start_seq, 1'b0, '0, bus.re_i);
                    state_q   <= S_RE;
                end
            end else if (next_bin) begin
                bin_q    <= bin_q + 1'b1;
                im_lat_q <= bus.im_i;
                if (bus.fifo_full_i) begin
                    state_q <= S_DROP;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= make_word(chan_q, fseq_q, 1'b0, bin_q + 1'b1, bus.re_i);
                    state_q   <= S_RE;
                end
            end else if (truncate) begin
                state_q <= S_DROP;
            end else if (state_q == S_IM) begin
                state_q <= last_bin ? S_IDLE : S_IM_WAIT;
            end
        end
    end

    assign bus.ready_o   = (state_q != S_RE);
    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_data_o = wr_data_q;
    assign frame_done_o  = frame_done_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer: directed frames plus random traffic against a
// frame-level reference model of owed words, sequence numbers and drop count.
module tb_fft_frame_packer;

    localparam int NB = 8;
    localparam int DW = 25;
    localparam int NC = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_done_o;
    logic [15:0] drop_cnt_o;

    fft_frame_packer_if #(.DATA_WIDTH(DW)) bus ();

    fft_frame_packer #(
        .N_BINS(NB), .DATA_WIDTH(DW), .NUM_CHAN(NC), .OUT_WIDTH(64)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .bus(bus),
        .frame_done_o(frame_done_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          compared   = 0;
    int          mismatched = 0;
    int          words_seen = 0;
    int          dones_seen = 0;
    logic [31:0] cap_im3    = '0;

    int          m_seq [16];
    bit          m_in_frame, m_pending_im, m_done_pending;
    int          m_bin, m_chan, m_fseq, m_pim, m_drop;
    bit          e_wr_en, e_done, e_ready;
    logic [63:0] e_wr_data;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] refWord(input int ch, input int sq, input bit imf,
                                            input int bin, input int sample);
        logic [63:0] w;
        w = {4'h8, 4'(ch), 8'(sq), imf, 15'(bin), 32'(sample)};
`ifdef FFT_FRAME_PACKER_PARITY_EN
        w[60] = ^w[59:0];
`endif
        return w;
    endfunction

    function automatic int rndSample();
        logic [DW-1:0] r;
        r = DW'($urandom);
        return int'($signed(r));
    endfunction

    function automatic void modelReset();
        foreach (m_seq[i]) m_seq[i] = 0;
        m_in_frame = 0; m_pending_im = 0; m_done_pending = 0;
        m_bin = 0; m_chan = 0; m_fseq = 0; m_pim = 0; m_drop = 0;
        e_wr_en = 0; e_done = 0; e_ready = 1; e_wr_data = '0;
    endfunction

    function automatic void addDrop();
        if (m_drop < 65535) m_drop++;
    endfunction

    // Frame-level view: a finished frame retires first, then an owed im word, else the new sample.
    function automatic void modelStep(input bit v, input bit s, input int c,
                                      input int re, input int im, input bit full);
        e_wr_en = 0;
        e_done  = 0;
        if (m_done_pending) begin
            m_seq[m_chan]  = (m_seq[m_chan] + 1) % 256;
            e_done         = 1;
            m_in_frame     = 0;
            m_done_pending = 0;
        end
        if (m_pending_im) begin
            m_pending_im = 0;
            if (full) begin
                addDrop();
                m_in_frame = 0;
            end else begin
                e_wr_en   = 1;
                e_wr_data = refWord(m_chan, m_fseq, 1'b1, m_bin, m_pim);
                if (m_bin == NB - 1) m_done_pending = 1;
            end
        end else if (v) begin
            if (s) begin
                if (m_in_frame) addDrop();
                if (full) begin
                    addDrop();
                    m_in_frame = 0;
                end else begin
                    m_in_frame = 1; m_bin = 0; m_chan = c; m_fseq = m_seq[c];
                    e_wr_en = 1; e_wr_data = refWord(c, m_fseq, 1'b0, 0, re);
                    m_pending_im = 1; m_pim = im;
                end
            end else if (m_in_frame) begin
                if (c != m_chan) begin
                    addDrop();
                    m_in_frame = 0;
                end else begin
                    m_bin++;
                    if (full) begin
                        addDrop();
                        m_in_frame = 0;
                    end else begin
                        e_wr_en = 1; e_wr_data = refWord(m_chan, m_fseq, 1'b0, m_bin, re);
                        m_pending_im = 1; m_pim = im;
                    end
                end
            end
        end
        e_ready = !m_pending_im;
    endfunction

    task automatic applyStimulus(input bit v, input bit s, input int c,
                                 input int re, input int im, input bit full);
        bus.valid_i     = v;
        bus.sync_i      = s;
        bus.chan_i      = 4'(c);
        bus.re_i        = DW'(re);
        bus.im_i        = DW'(im);
        bus.fifo_full_i = full;
        modelStep(v, s, c, re, im, full);
        @(posedge clk_i);
        #1;
        if (bus.wr_en_o) begin
            words_seen++;
            if (bus.wr_data_o[47] && bus.wr_data_o[46:32] == 15'd3) cap_im3 = bus.wr_data_o[31:0];
        end
        if (frame_done_o) dones_seen++;
        checkOutput("ready", bus.ready_o, e_ready);
        checkOutput("wr_en", bus.wr_en_o, e_wr_en);
        if (e_wr_en) checkOutput("wr_data", bus.wr_data_o, e_wr_data);
        checkOutput("frame_done", frame_done_o, e_done);
        checkOutput("drop_cnt", drop_cnt_o, m_drop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.valid_i = 0; bus.sync_i = 0; bus.chan_i = '0;
        bus.re_i = '0; bus.im_i = '0; bus.fifo_full_i = 0;
        @(posedge clk_i);
        #1;
        modelReset();
        checkOutput("rst_ready", bus.ready_o, 1);
        checkOutput("rst_wr_en", bus.wr_en_o, 0);
        checkOutput("rst_wr_data", bus.wr_data_o, 0);
        checkOutput("rst_frame_done", frame_done_o, 0);
        checkOutput("rst_drop_cnt", drop_cnt_o, 0);
        rst_n = 1'b1;
        words_seen = 0;
        dones_seen = 0;
    endtask

    task automatic sendFrame(input int ch, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            applyStimulus(1, k == 0, ch, rndSample(), rndSample(), 0);
            applyStimulus(0, 0, ch, 0, 0, 0);
        end
    endtask

    initial begin
        int          cur_ch;
        bit          v;
        logic [59:0] par_bits;
        logic [3:0]  exp_hdr;

        // Clean frame: re=k, im=-k, every second cycle.
        doReset();
        for (int k = 0; k < NB; k++) begin
            applyStimulus(1, k == 0, 0, k, -k, 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        idle(2);
        checkOutput("t1_words", words_seen, 16);
        checkOutput("t1_done_pulses", dones_seen, 1);
        checkOutput("t1_im3_low", cap_im3, 32'hFFFF_FFFD);
        applyStimulus(1, 1, 0, 5, 5, 0);
        checkOutput("t1_seq_next", bus.wr_data_o[55:48], 1);

        // FIFO full while bin 4's re word is out.
        doReset();
        sendFrame(0, 0, 3);
        applyStimulus(1, 0, 0, 4, -4, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t2_words", words_seen, 9);
        checkOutput("t2_drop", drop_cnt_o, 1);
        sendFrame(0, 5, 7);
        applyStimulus(1, 1, 0, 9, 9, 0);
        checkOutput("t2_seq_restart", bus.wr_data_o[55:48], 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        sendFrame(0, 1, NB - 1);
        idle(2);
        checkOutput("t2_done_pulses", dones_seen, 1);

        // Early sync on bin 5.
        doReset();
        sendFrame(0, 0, 4);
        applyStimulus(1, 1, 0, 100, -100, 0);
        checkOutput("t3_drop", drop_cnt_o, 1);
        checkOutput("t3_new_bin", bus.wr_data_o[46:32], 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        sendFrame(0, 1, NB - 1);
        idle(2);
        checkOutput("t3_done_pulses", dones_seen, 1);

        // Reset while bin 2's im word is out.
        sendFrame(0, 0, 2);
        checkOutput("t5_in_im", bus.wr_data_o[47], 1);
        doReset();

        // Two channels.
        sendFrame(2, 0, NB - 1);
        idle(2);
        sendFrame(3, 0, NB - 1);
        idle(2);
        applyStimulus(1, 1, 2, 1, 1, 0);
        checkOutput("t4_chan2", bus.wr_data_o[59:56], 2);
        checkOutput("t4_seq2", bus.wr_data_o[55:48], 1);
        idle(2);
        applyStimulus(1, 1, 3, 1, 1, 0);
        checkOutput("t4_chan3", bus.wr_data_o[59:56], 3);
        checkOutput("t4_seq3", bus.wr_data_o[55:48], 1);
        idle(2);

        // Header nibble with re=1, bin 0, ch 0.
        doReset();
        applyStimulus(1, 1, 0, 1, 0, 0);
        par_bits = 60'd1;
`ifdef FFT_FRAME_PACKER_PARITY_EN
        exp_hdr = {3'b100, ^par_bits};
`else
        exp_hdr = 4'h8;
`endif
        checkOutput("t6_header", bus.wr_data_o[63:60], exp_hdr);
        idle(2);

        // Random traffic.
        doReset();
        cur_ch = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_ch = $urandom_range(0, NC - 1);
            v = ($urandom_range(0, 1) == 1);
            applyStimulus(v, v && ($urandom_range(0, 9) == 0), cur_ch,
                          rndSample(), rndSample(), $urandom_range(0, 24) == 0);
        end

        // Sequence wrap: 257 back-to-back frames on ch1 with valid held high.
        doReset();
        for (int f = 0; f < 257; f++) begin
            for (int k = 0; k < NB; k++) begin
                applyStimulus(1, k == 0, 1, rndSample(), rndSample(), 0);
                applyStimulus(1, 0, 1, rndSample(), rndSample(), 0);
            end
        end
        idle(2);
        checkOutput("wrap_done_pulses", dones_seen, 257);
        applyStimulus(1, 1, 1, 7, 7, 0);
        checkOutput("wrap_seq", bus.wr_data_o[55:48], 1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
